// File: rtl/trivium_host_if.sv
// Word-parallel host front end for trivium_top: serial key/IV load, warm-up wait,
// 32-bit plaintext serialization and ciphertext word reassembly.
module trivium_host_if (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        ovf_o,
  output logic        core_dat_o,
  output logic        core_init_o,
  output logic        core_end_o,
  input  logic        core_dat_i,
  input  logic        core_busy_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_KEY = 3'd1;
  localparam logic [2:0] S_LOAD_IV  = 3'd2;
  localparam logic [2:0] S_WARMUP   = 3'd3;
  localparam logic [2:0] S_STREAM   = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;
  localparam logic [2:0] S_END      = 3'd6;

  logic [2:0]   state_q, state_d;
  logic         load_ready_q;
  logic [159:0] ld_sh_q;
  logic [6:0]   ld_cnt_q;
  logic         busy_seen_q;
  logic         warm_min_q;
  logic [31:0]  tx_sh_q;
  logic [4:0]   tx_cnt_q;
  logic         tx_active_q;
  logic         rx_en_q;
  logic [4:0]   rx_cnt_q;
  logic [30:0]  rx_sh_q;
  logic [31:0]  out_data_q;
  logic         out_valid_q;
  logic         ovf_q;

  logic load_acc, in_acc, tx_last, loading, ld_last, rx_done;
  logic [31:0] rx_word;

  assign loading  = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_IV);
  assign ld_last  = (ld_cnt_q == 7'd79);
  assign load_acc = load_valid_i && load_ready_q;
  assign tx_last  = tx_active_q && (tx_cnt_q == 5'd31);
  assign in_ready_o = (state_q == S_STREAM) && (!tx_active_q || tx_cnt_q == 5'd31);
  assign in_acc   = in_valid_i && in_ready_o;
  assign rx_done  = rx_en_q && (rx_cnt_q == 5'd31);
  assign rx_word  = {core_dat_i, rx_sh_q};

  assign load_ready_o = load_ready_q;
  assign core_init_o  = loading;
  assign core_end_o   = (state_q == S_END);
  assign core_dat_o   = loading ? ld_sh_q[0] : (tx_active_q & tx_sh_q[0]);
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign ovf_o        = ovf_q;

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (load_acc) state_d = S_LOAD_KEY;
      S_LOAD_KEY: if (ld_last) state_d = S_LOAD_IV;
      S_LOAD_IV:  if (ld_last) state_d = S_WARMUP;
      // Busy must be seen high then low before the keystream is valid.
      S_WARMUP:   if (busy_seen_q && !core_busy_i && warm_min_q) state_d = S_STREAM;
      S_STREAM:   if (tx_last && !in_valid_i) state_d = S_FLUSH;
      S_FLUSH:    state_d = S_END;
      S_END:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      load_ready_q <= 1'b0;
      ld_sh_q      <= '0;
      ld_cnt_q     <= '0;
      busy_seen_q  <= 1'b0;
      warm_min_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= (state_d == S_IDLE);
      if (load_acc) begin
        ld_sh_q     <= {iv_i, key_i};
        ld_cnt_q    <= '0;
        busy_seen_q <= 1'b0;
        warm_min_q  <= 1'b0;
      end else if (loading) begin
        ld_sh_q  <= {1'b0, ld_sh_q[159:1]};
        ld_cnt_q <= ld_last ? 7'd0 : ld_cnt_q + 7'd1;
      end
      if (state_q == S_WARMUP) begin
        warm_min_q <= 1'b1;
        if (core_busy_i) busy_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      tx_active_q <= 1'b0;
    end else if (in_acc) begin
      tx_sh_q     <= in_data_i;
      tx_cnt_q    <= '0;
      tx_active_q <= 1'b1;
    end else if (tx_active_q) begin
      tx_sh_q     <= {1'b0, tx_sh_q[31:1]};
      tx_cnt_q    <= tx_cnt_q + 5'd1;
      tx_active_q <= !tx_last;
    end
  end

  // Ciphertext trails plaintext by one cycle; bits enter at the top so the
  // first captured bit lands in position 0 once the word is complete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_en_q  <= 1'b0;
      rx_cnt_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_en_q <= tx_active_q;
      if (rx_en_q) begin
        rx_sh_q  <= {core_dat_i, rx_sh_q[30:1]};
        rx_cnt_q <= rx_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (load_acc) ovf_q <= 1'b0;
      if (rx_done) begin
        if (!out_valid_q || out_ready_i) begin
          out_data_q  <= rx_word;
          out_valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_host_if.sv
// Directed bench for trivium_host_if with a behavioural core: ciphertext = plaintext ^ 1, one cycle later.
module tb_trivium_host_if;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [79:0] key_i = '0;
  logic [79:0] iv_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic        ovf_o;
  logic        core_dat_o, core_init_o, core_end_o;
  logic        core_ret = 1'b0;
  logic        core_busy_i = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) core_ret <= core_dat_o ^ 1'b1;

  trivium_host_if dut (
    .clk_i(clk), .rst_i(rst_i),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .key_i(key_i), .iv_i(iv_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .ovf_o(ovf_o),
    .core_dat_o(core_dat_o), .core_init_o(core_init_o), .core_end_o(core_end_o),
    .core_dat_i(core_ret), .core_busy_i(core_busy_i)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({load_ready_o, in_ready_o, out_valid_o, ovf_o, core_dat_o, core_init_o, core_end_o} !== 7'b0 || out_data_o !== 32'h0) begin
      failures++; $display("FAIL reset_outputs got=%b/%h exp=0", {load_ready_o, in_ready_o, out_valid_o, ovf_o, core_dat_o, core_init_o, core_end_o}, out_data_o);
    end
    rst_i = 1'b0;
    #1;
    checks++; if (load_ready_o !== 1'b0) begin failures++; $display("FAIL reset_release_ready_early got=%b exp=0", load_ready_o); end
    @(negedge clk);
    checks++; if (load_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", load_ready_o); end
  endtask

  task automatic test_load();
    logic [159:0] exp_bits;
    key_i = 80'h0123456789ABCDEF0123;
    iv_i  = 80'hFFFF0000FFFF0000FFFF;
    exp_bits = {iv_i, key_i};
    checks++; if (core_init_o !== 1'b0) begin failures++; $display("FAIL load_init_before got=%b exp=0", core_init_o); end
    load_valid_i = 1'b1;
    @(negedge clk);
    load_valid_i = 1'b0;
    for (int k = 0; k < 160; k++) begin
      checks++; if (core_dat_o !== exp_bits[k] || core_init_o !== 1'b1 || in_ready_o !== 1'b0) begin
        failures++; $display("FAIL load_bit k=%0d got dat=%b init=%b rdy=%b exp dat=%b init=1 rdy=0", k, core_dat_o, core_init_o, in_ready_o, exp_bits[k]);
      end
      @(negedge clk);
    end
    checks++; if (core_init_o !== 1'b0 || load_ready_o !== 1'b0) begin
      failures++; $display("FAIL load_init_after got init=%b ldrdy=%b exp 0/0", core_init_o, load_ready_o);
    end
  endtask

  task automatic test_warmup();
    in_valid_i = 1'b1;
    in_data_i  = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL warmup_pre_busy got=%b exp=0", in_ready_o); end
    end
    core_busy_i = 1'b1;
    for (int i = 0; i < 1152; i++) begin
      @(negedge clk);
      checks++; if (in_ready_o !== 1'b0 || core_dat_o !== 1'b0) begin
        failures++; $display("FAIL warmup_busy i=%0d got rdy=%b dat=%b exp 0/0", i, in_ready_o, core_dat_o);
      end
    end
    core_busy_i = 1'b0;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL warmup_fall_cycle got=%b exp=0", in_ready_o); end
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b1 || core_dat_o !== 1'b0) begin
      failures++; $display("FAIL warmup_stream_entry got rdy=%b dat=%b exp 1/0", in_ready_o, core_dat_o);
    end
  endtask

  // Entered in the accept cycle A with DEADBEEF offered and in_ready_o high.
  task automatic test_data_path();
    logic [31:0] w0, w1;
    w0 = 32'hDEADBEEF;
    w1 = 32'h00000000;
    out_ready_i = 1'b0;
    for (int rel = 1; rel <= 67; rel++) begin
      @(negedge clk);
      if (rel == 1) in_data_i = w1;
      if (rel <= 32) begin
        checks++; if (core_dat_o !== w0[rel-1]) begin failures++; $display("FAIL dp_tx0 rel=%0d got=%b exp=%b", rel, core_dat_o, w0[rel-1]); end
      end else if (rel <= 64) begin
        checks++; if (core_dat_o !== w1[rel-33]) begin failures++; $display("FAIL dp_tx1 rel=%0d got=%b exp=%b", rel, core_dat_o, w1[rel-33]); end
      end
      if (rel == 31 || rel == 33) begin
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL dp_ready_low rel=%0d got=%b exp=0", rel, in_ready_o); end
      end
      if (rel == 32 || rel == 64) begin
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL dp_ready_boundary rel=%0d got=%b exp=1", rel, in_ready_o); end
      end
      if (rel == 33) in_valid_i = 1'b0;
      if (rel == 33) begin
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL dp_out_early got=%b exp=0", out_valid_o); end
      end
      if (rel == 34 || rel == 50) begin
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h21524110) begin
          failures++; $display("FAIL dp_word0 rel=%0d got v=%b d=%h exp v=1 d=21524110", rel, out_valid_o, out_data_o);
        end
      end
      if (rel == 65) begin
        out_ready_i = 1'b1;
        checks++; if (core_end_o !== 1'b0) begin failures++; $display("FAIL dp_end_early got=%b exp=0", core_end_o); end
      end
      if (rel == 66) begin
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hFFFFFFFF || ovf_o !== 1'b0 || core_end_o !== 1'b1) begin
          failures++; $display("FAIL dp_word1_replace got v=%b d=%h ovf=%b end=%b exp v=1 d=ffffffff ovf=0 end=1", out_valid_o, out_data_o, ovf_o, core_end_o);
        end
      end
      if (rel == 67) begin
        checks++; if (out_valid_o !== 1'b0 || load_ready_o !== 1'b1 || core_end_o !== 1'b0) begin
          failures++; $display("FAIL dp_drain_idle got v=%b ldrdy=%b end=%b exp 0/1/0", out_valid_o, load_ready_o, core_end_o);
        end
      end
    end
    out_ready_i = 1'b0;
  endtask

  // Load new key/IV, run a short warm-up, return in a cycle with in_ready_o high.
  task automatic start_session(input logic [79:0] key, input logic [79:0] iv);
    int n;
    n = 0;
    in_valid_i = 1'b0;
    while (load_ready_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (load_ready_o !== 1'b1) begin failures++; $display("FAIL sess_load_ready timeout got=%b exp=1", load_ready_o); end
    key_i = key;
    iv_i  = iv;
    load_valid_i = 1'b1;
    @(negedge clk);
    load_valid_i = 1'b0;
    checks++; if (core_init_o !== 1'b1 || ovf_o !== 1'b0) begin
      failures++; $display("FAIL sess_load_accept got init=%b ovf=%b exp 1/0", core_init_o, ovf_o);
    end
    n = 0;
    while (core_init_o !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n != 160) begin failures++; $display("FAIL sess_init_len got=%0d exp=160", n); end
    core_busy_i = 1'b1;
    repeat (8) @(negedge clk);
    core_busy_i = 1'b0;
    n = 0;
    while (in_ready_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n != 1) begin failures++; $display("FAIL sess_stream_entry cycles=%0d exp=1", n); end
  endtask

  task automatic test_termination();
    start_session(80'h1, 80'h2);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h0000FFFF;
    for (int rel = 1; rel <= 36; rel++) begin
      @(negedge clk);
      if (rel == 1) in_valid_i = 1'b0;
      checks++; if (core_end_o !== (rel == 34)) begin failures++; $display("FAIL term_end_pulse rel=%0d got=%b exp=%b", rel, core_end_o, rel == 34); end
      if (rel == 33 || rel == 34) begin
        checks++; if (load_ready_o !== 1'b0 || in_ready_o !== 1'b0) begin
          failures++; $display("FAIL term_not_idle rel=%0d got ldrdy=%b rdy=%b exp 0/0", rel, load_ready_o, in_ready_o);
        end
      end
      if (rel == 34) begin
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hFFFF0000) begin
          failures++; $display("FAIL term_word got v=%b d=%h exp v=1 d=ffff0000", out_valid_o, out_data_o);
        end
      end
      if (rel == 35) begin
        checks++; if (load_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
          failures++; $display("FAIL term_idle got ldrdy=%b v=%b exp 1/0", load_ready_o, out_valid_o);
        end
      end
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    start_session(80'h3, 80'h4);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h12345678;
    for (int rel = 1; rel <= 70; rel++) begin
      @(negedge clk);
      if (rel == 1) in_data_i = 32'hA5A5A5A5;
      if (rel == 33) in_valid_i = 1'b0;
      if (rel == 34 || rel == 65) begin
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hEDCBA987 || ovf_o !== 1'b0) begin
          failures++; $display("FAIL ovr_first rel=%0d got v=%b d=%h ovf=%b exp v=1 d=edcba987 ovf=0", rel, out_valid_o, out_data_o, ovf_o);
        end
      end
      if (rel == 66 || rel == 70) begin
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'hEDCBA987 || ovf_o !== 1'b1) begin
          failures++; $display("FAIL ovr_sticky rel=%0d got v=%b d=%h ovf=%b exp v=1 d=edcba987 ovf=1", rel, out_valid_o, out_data_o, ovf_o);
        end
      end
    end
  endtask

  // Follows test_overrun: the new load must clear ovf_o while out_valid_o is still held.
  task automatic test_reset_mid_stream();
    start_session(80'h5, 80'h6);
    in_valid_i = 1'b1;
    in_data_i  = 32'h00000400;
    for (int rel = 1; rel <= 11; rel++) begin
      @(negedge clk);
      if (rel == 1) in_valid_i = 1'b0;
    end
    checks++; if (core_dat_o !== 1'b1 || out_valid_o !== 1'b1 || ovf_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_before got dat=%b v=%b ovf=%b exp 1/1/0", core_dat_o, out_valid_o, ovf_o);
    end
    rst_i = 1'b1;
    #1;
    checks++; if ({load_ready_o, in_ready_o, out_valid_o, ovf_o, core_dat_o, core_init_o, core_end_o} !== 7'b0 || out_data_o !== 32'h0) begin
      failures++; $display("FAIL rst_mid_async got=%b/%h exp=0", {load_ready_o, in_ready_o, out_valid_o, ovf_o, core_dat_o, core_init_o, core_end_o}, out_data_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (load_ready_o !== 1'b1 || core_init_o !== 1'b0 || in_ready_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle got ldrdy=%b init=%b rdy=%b exp 1/0/0", load_ready_o, core_init_o, in_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_warmup();
    test_data_path();
    test_termination();
    test_overrun();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trivium_host_if.md
# trivium_host_if

Word-parallel host front end for `trivium_top`. It drives the core's bit-serial interface from the other side:
- loads an 80-bit key and 80-bit IV serially;
- waits out the core's warm-up;
- serializes 32-bit plaintext words into the core;
- reassembles the returned ciphertext bits into 32-bit words.

It sits between a bus or register-file host and `trivium_top`, replacing bench-style bit banging with synthesizable RTL.

## Interface
- No parameters; all widths are fixed by the core (key/IV 80, word 32).
- `clk_i` in 1: clock, all logic rising-edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `load_valid_i` in 1: key/IV load request.
- `load_ready_o` out 1: high only in IDLE.
- `key_i` in 80: key, sent LSB first.
- `iv_i` in 80: IV, sent LSB first.
- `in_valid_i` in 1: plaintext word valid.
- `in_ready_o` out 1: word accepted when `in_valid_i & in_ready_o`.
- `in_data_i` in 32: plaintext word.
- `out_valid_o` out 1: ciphertext word valid; held until `out_ready_i`.
- `out_ready_i` in 1: consumer accept.
- `out_data_o` out 32: ciphertext word (bit 0 = first serial bit).
- `ovf_o` out 1: sticky output overrun; cleared on load accept.
- `core_dat_o` out 1: to `trivium_top.dat_i`.
- `core_init_o` out 1: to `init_i`.
- `core_end_o` out 1: to `end_i`.
- `core_dat_i` in 1: from `dat_o`.
- `core_busy_i` in 1: from `busy_init_o`.

## Operation
- States:
  - **IDLE:** waiting for a key/IV load request.
  - **LOAD_KEY:** 80 key bits sent.
  - **LOAD_IV:** 80 IV bits sent.
  - **WARMUP:** waiting for the core's warm-up to finish.
  - **STREAM:** words serialized into the core and ciphertext collected.
  - **FLUSH:** capturing the final ciphertext bit after the stream stops.
  - **END:** one-cycle stream termination.
- **IDLE:**
  - On a load handshake, latch `key_i`/`iv_i`, clear `ovf_o`, go to LOAD_KEY.
  - `in_ready_o` is low in IDLE.
- **LOAD_KEY, LOAD_IV:**
  - 7-bit counter 0..79 per phase; one bit per cycle on `core_dat_o`, LSB first.
  - `core_init_o` is high for all 160 cycles.
- **WARMUP:**
  - `core_init_o` is low.
  - Exit to STREAM once `core_busy_i` has been sampled high and then sampled low, with at least 2 cycles spent in WARMUP.
  - `core_busy_i` never rising leaves the block in WARMUP; reset is the only exit.
- **STREAM, first word:**
  - Keystream starts with the first data bit presented after busy falls; idle cycles before the first word consume nothing.
  - `in_ready_o` is high until the first word is accepted.
- **STREAM, word transfer:**
  - An accepted word loads the tx shifter; bits go out LSB first, one per cycle.
  - A 5-bit tx counter tracks the bits.
- **STREAM, continuation:**
  - `in_ready_o` is high on the cycle bit 31 is driven, giving contiguous back-to-back words.
  - If `in_valid_i` is low at that boundary, go to FLUSH.
- **Rx path:**
  - The core returns each ciphertext bit one cycle after its plaintext bit.
  - The rx shifter captures `core_dat_i` into bit position k for the k-th bit.
  - On the 32nd capture the word moves to the output register.
- **Output register:**
  - If `out_valid_o` is low, or `out_ready_i` is high that cycle, the new word is written and `out_valid_o` is set.
  - Otherwise the new word is dropped, the old word is kept, and `ovf_o` is set.
- **FLUSH:** capture the final ciphertext bit (1 cycle), then go to END.
- **END:**
  - `core_end_o` is high for exactly 1 cycle, then IDLE.
  - The session is over; continuing requires a new key/IV load.
- **Drain:** the output register drains independently of state, including in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters and shifters 0; `load_ready_o` rises the first cycle after reset release.
- **Mid-operation reset:** asserting `rst_i` mid-operation drops `core_init_o`, `core_end_o`, `core_dat_o` and `out_valid_o` immediately (asynchronous).
- **Load handshake at cycle T:**
  - Key bit k on `core_dat_o` at T+1+k.
  - IV bit k at T+81+k.
  - `core_init_o` high from T+1 through T+160; WARMUP from T+161.
- **Word accepted at cycle A:**
  - Bit k driven at A+1+k.
  - Captured at A+2+k.
  - `out_data_o`/`out_valid_o` visible at A+34 (latency 34).
- **Back-to-back:** next accept at A+32, first bit at A+33; no bubble.
- **Stream end:**
  - Last word accepted at A with `in_valid_i` low at A+32.
  - FLUSH at A+33, END (`core_end_o` = 1) at A+34, IDLE with `load_ready_o` = 1 at A+35.
- **Simultaneous drain and new word:** `out_ready_i` high in the same cycle a new word completes is a clean replace, with no overflow.

## Test plan
- **Load timing:**
  - Stimulus: key 80'h0123456789ABCDEF0123, IV 80'hFFFF0000FFFF0000FFFF.
  - Response: `core_dat_o` sequence equals key bits 0..79 then IV bits 0..79; `core_init_o` high for exactly 160 cycles.
- **Warm-up gating:**
  - Stimulus: core model holds busy high 1152 cycles.
  - Response: `in_ready_o` stays low until the cycle after busy is sampled low; a word offered early is not consumed.
- **Data path:**
  - Stimulus: core model returns `dat_i` XOR 1 with 1-cycle latency; words 32'hDEADBEEF then 32'h00000000 back-to-back.
  - Response: `out_data_o` = 32'h21524110 at A+34, then 32'hFFFFFFFF at A+66; `core_dat_o` has no gap.
- **Termination:**
  - Stimulus: one word, then drop `in_valid_i`.
  - Response: `core_end_o` is a single pulse at A+34; `load_ready_o` = 1 at A+35.
- **Overrun:**
  - Stimulus: `out_ready_i` = 0 across two completed words.
  - Response: `ovf_o` = 1, `out_data_o` still holds the first word; the next load clears `ovf_o`.
- **Reset mid-stream:**
  - Stimulus: assert `rst_i` at bit 10 of a word.
  - Response: all outputs 0 in the same cycle; after release, IDLE with `load_ready_o` = 1.
